bvh_traverse_unit: RTL and testbench
====================================

BVH_TRAVERSE_UNIT -- requirements
Module: bvh_traverse_unit

Interface
REQ-001 SHALL have parameter NODE_W, default 16: node index width; index MSB=1 marks a leaf or empty child.
REQ-002 SHALL have parameter PRIM_IDX_W, default 16: primitive start index width.
REQ-003 SHALL have parameter PRIM_CNT_W, default 8: primitive count width.
REQ-004 SHALL have parameter STACK_DEPTH, default 16: node stack entries, minimum 2.
REQ-005 SHALL use one clock and a synchronous, active-high reset, ports as below.
REQ-006 SHALL have port clk  in  1: rising-edge clock.
REQ-007 SHALL have port reset  in  1: synchronous active-high reset.
REQ-008 SHALL have port start  in  1: one-cycle strobe that begins traversal at root node 0.
REQ-009 SHALL have port abort  in  1: cancels traversal.
REQ-010 SHALL have port node_req  out  1: one-cycle node fetch request.
REQ-011 SHALL have port node_addr  out  NODE_W: index of the node being fetched.
REQ-012 SHALL have port node_valid  in  1: fetched node data and hit results are valid this cycle.
REQ-013 SHALL have port node_hit  in  1: ray hits the node AABB.
REQ-014 SHALL have port child_idx[2]  in  NODE_W: child node indices.
REQ-015 SHALL have port child_hit[2]  in  1: ray hits the child AABB.
REQ-016 SHALL have port leaf_start[2]  in  PRIM_IDX_W: leaf child primitive start.
REQ-017 SHALL have port leaf_num[2]  in  PRIM_CNT_W: leaf child primitive count.
REQ-018 SHALL have port leaf_valid  out  1: a leaf record is offered.
REQ-019 SHALL have port leaf_ready  in  1: downstream accepts the offered leaf.
REQ-020 SHALL have port out_start  out  PRIM_IDX_W: primitive start of the offered leaf.
REQ-021 SHALL have port out_num  out  PRIM_CNT_W: primitive count of the offered leaf.
REQ-022 SHALL have port busy  out  1: traversal in progress.
REQ-023 SHALL have port done  out  1: traversal complete; held high until start or abort.
REQ-024 SHALL have port overflow  out  1: sticky flag, a child was dropped because the stack was full.
REQ-025 SHALL have port nodes_visited  out  16: count of nodes fetched, saturating at 0xFFFF.

Function
REQ-026 SHALL implement states IDLE, FETCH, WAIT, EMIT0, EMIT1, POP, DONE.
REQ-027 IDLE or DONE with start: set sp=0, cur=0, clear overflow, done and nodes_visited; go to FETCH next cycle. start in any other state SHALL be ignored.
REQ-028 FETCH: drive node_req=1 and node_addr=cur for exactly one cycle; increment nodes_visited (saturating); go to WAIT.
REQ-029 WAIT: hold node_req=0 until node_valid. When node_valid arrives, register all node inputs; go to EMIT0 if node_hit=1, else to POP.
REQ-030 On a node_valid with node_hit=1, SHALL push internal children (index MSB=0) in that same cycle, child[1] first and child[0] second, so child[0] pops first. Hit results SHALL NOT gate internal children.
REQ-031 If a push would exceed STACK_DEPTH, SHALL drop that child and set overflow. Any child that still fits SHALL be pushed, with child[1] taking priority.
REQ-032 EMIT0: if child[0] is a leaf with child_hit[0]=1 and leaf_num[0]!=0, drive leaf_valid=1 with out_start and out_num. Hold them stable until leaf_ready=1, then go to EMIT1. Otherwise go to EMIT1 immediately with leaf_valid=0.
REQ-033 EMIT1: same rule as EMIT0 for child[1]; then go to POP.
REQ-034 POP: if sp=0, go to DONE. Otherwise set sp=sp-1 and cur=stack[sp-1], and go to FETCH.
REQ-035 DONE: done=1, busy=0.
REQ-036 busy SHALL be 1 in FETCH, WAIT, EMIT0, EMIT1 and POP; out_start and out_num SHALL be 0 whenever leaf_valid=0.
REQ-037 abort in any state SHALL take effect next cycle: state IDLE, leaf_valid=0, busy=0, done=0, sp=0. Any pending node_valid is ignored. abort SHALL have priority over start in the same cycle.
REQ-038 node_valid outside WAIT SHALL be ignored.
REQ-039 Stack pointer width SHALL be clog2(STACK_DEPTH+1); sp SHALL never exceed STACK_DEPTH or underflow.
REQ-040 Minimum per-node latency, from FETCH to the next FETCH with no leaves emitted, SHALL be 4 cycles plus the memory latency.

Reset
REQ-041 reset SHALL force state IDLE, sp=0, cur=0, and every output to 0. reset SHALL override start and abort.
REQ-042 reset asserted mid-traversal SHALL discard the stack and any pending leaf, with no further node_req.

Verification
REQ-043 Root miss: start, node0 returns node_hit=0 -> no leaf_valid, done=1, nodes_visited=1.
REQ-044 Two-level tree: root children 1 and 2 internal; node1 has leaves (start 0, num 3) and (start 3, num 2), both hit; node2 misses -> fetch order 0,1,2. Leaves (0,3) then (3,2) are emitted, done=1, nodes_visited=3.
REQ-045 Backpressure: hold leaf_ready=0 for 5 cycles during EMIT0 -> leaf_valid and out_start/out_num stay stable, no node_req is issued, and exactly one transfer occurs.
REQ-046 Overflow: STACK_DEPTH=2, a chain where every node has two internal hit children -> overflow=1 and traversal still reaches DONE.
REQ-047 Abort in WAIT, then node_valid arrives -> IDLE, no leaf_valid. A following start restarts at node_addr=0 with nodes_visited=1.
REQ-048 Leaf with child_hit=1 and leaf_num=0, and a leaf with child_hit=0 -> neither is emitted.

Source files
------------

// File: rtl/bvh_traverse_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bvh_traverse_unit : stack-based BVH walker that fetches nodes and emits hit leaves
// Revision: 1.0
// ---------------------------------------------------------------------------
module bvh_traverse_unit #(
  parameter int NODE_W      = 16,
  parameter int PRIM_IDX_W  = 16,
  parameter int PRIM_CNT_W  = 8,
  parameter int STACK_DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  node_req,
  output logic [NODE_W-1:0]     node_addr,
  input  logic                  node_valid,
  input  logic                  node_hit,
  input  logic [NODE_W-1:0]     child_idx  [2],
  input  logic                  child_hit  [2],
  input  logic [PRIM_IDX_W-1:0] leaf_start [2],
  input  logic [PRIM_CNT_W-1:0] leaf_num   [2],
  output logic                  leaf_valid,
  input  logic                  leaf_ready,
  output logic [PRIM_IDX_W-1:0] out_start,
  output logic [PRIM_CNT_W-1:0] out_num,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [15:0]           nodes_visited
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] DEPTH    = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0] DEPTH_M1 = SP_W'(STACK_DEPTH - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_EMIT0 = 3'd3;
  localparam logic [2:0] S_EMIT1 = 3'd4;
  localparam logic [2:0] S_POP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            state;
  logic [2:0]            state_nx;
  logic [SP_W-1:0]       sp;
  logic [NODE_W-1:0]     cur;
  logic [NODE_W-1:0]     stack [STACK_DEPTH];
  logic [1:0]            emit_ok;
  logic [PRIM_IDX_W-1:0] lstart [2];
  logic [PRIM_CNT_W-1:0] lnum   [2];

  logic              accept;
  logic              push0;
  logic              push1;
  logic              room1;
  logic              room2;
  logic              wr_a;
  logic              wr_b;
  logic              drop;
  logic [NODE_W-1:0] wr_a_data;

  assign accept = (state == S_WAIT) && node_valid && !abort;
  assign push1  = accept && node_hit && !child_idx[1][NODE_W-1];
  assign push0  = accept && node_hit && !child_idx[0][NODE_W-1];
  assign room1  = (sp < DEPTH);
  assign room2  = (sp < DEPTH_M1);

  // child[1] lands first so child[0] sits on top; child[1] wins the last free slot
  always_comb begin
    wr_a      = 1'b0;
    wr_b      = 1'b0;
    drop      = 1'b0;
    wr_a_data = child_idx[1];
    if (push1) begin
      if (room1) begin
        wr_a = 1'b1;
        if (push0) begin
          if (room2) wr_b = 1'b1;
          else       drop = 1'b1;
        end
      end else begin
        drop = 1'b1;
      end
    end else if (push0) begin
      wr_a_data = child_idx[0];
      if (room1) wr_a = 1'b1;
      else       drop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_a) stack[IDX_W'(sp)] <= wr_a_data;
    if (wr_b) stack[IDX_W'(sp + SP_W'(1))] <= child_idx[0];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_FETCH;
      S_FETCH:        state_nx = S_WAIT;
      S_WAIT:         if (node_valid) state_nx = node_hit ? S_EMIT0 : S_POP;
      S_EMIT0:        if (!emit_ok[0] || leaf_ready) state_nx = S_EMIT1;
      S_EMIT1:        if (!emit_ok[1] || leaf_ready) state_nx = S_POP;
      S_POP:          state_nx = (sp == '0) ? S_DONE : S_FETCH;
      default:        state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp            <= '0;
      cur           <= '0;
      overflow      <= 1'b0;
      nodes_visited <= '0;
      emit_ok       <= '0;
    end else if (abort) begin
      sp      <= '0;
      emit_ok <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            sp            <= '0;
            cur           <= '0;
            overflow      <= 1'b0;
            nodes_visited <= '0;
          end
        end
        S_FETCH: begin
          if (nodes_visited != 16'hFFFF) nodes_visited <= nodes_visited + 16'd1;
        end
        S_WAIT: begin
          if (node_valid) begin
            for (int i = 0; i < 2; i++) begin
              emit_ok[i] <= child_idx[i][NODE_W-1] && child_hit[i] && (leaf_num[i] != '0);
              lstart[i]  <= leaf_start[i];
              lnum[i]    <= leaf_num[i];
            end
            sp <= sp + SP_W'(wr_a) + SP_W'(wr_b);
            if (drop) overflow <= 1'b1;
          end
        end
        S_POP: begin
          if (sp != '0) begin
            sp  <= sp - SP_W'(1);
            cur <= stack[IDX_W'(sp - SP_W'(1))];
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    node_req   = (state == S_FETCH);
    node_addr  = node_req ? cur : '0;
    busy       = (state == S_FETCH) || (state == S_WAIT) || (state == S_EMIT0) ||
                 (state == S_EMIT1) || (state == S_POP);
    done       = (state == S_DONE);
    leaf_valid = 1'b0;
    out_start  = '0;
    out_num    = '0;
    if (state == S_EMIT0 && emit_ok[0]) begin
      leaf_valid = 1'b1;
      out_start  = lstart[0];
      out_num    = lnum[0];
    end else if (state == S_EMIT1 && emit_ok[1]) begin
      leaf_valid = 1'b1;
      out_start  = lstart[1];
      out_num    = lnum[1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bvh_traverse_unit.sv
`default_nettype none
// Bench for bvh_traverse_unit: table of single-node trees plus multi-cycle sequences.
module tb_bvh_traverse_unit;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic        node_req;
  logic [15:0] node_addr;
  logic        node_valid, node_hit;
  logic [15:0] child_idx  [2];
  logic        child_hit  [2];
  logic [15:0] leaf_start [2];
  logic [7:0]  leaf_num   [2];
  logic        leaf_valid, leaf_ready;
  logic [15:0] out_start;
  logic [7:0]  out_num;
  logic        busy, done, overflow;
  logic [15:0] nodes_visited;

  always #5 clk = ~clk;

  bvh_traverse_unit #(.NODE_W(16), .PRIM_IDX_W(16), .PRIM_CNT_W(8), .STACK_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .node_req(node_req), .node_addr(node_addr), .node_valid(node_valid), .node_hit(node_hit),
    .child_idx(child_idx), .child_hit(child_hit), .leaf_start(leaf_start), .leaf_num(leaf_num),
    .leaf_valid(leaf_valid), .leaf_ready(leaf_ready), .out_start(out_start), .out_num(out_num),
    .busy(busy), .done(done), .overflow(overflow), .nodes_visited(nodes_visited)
  );

  // node memory model
  logic        mem_hit [16];
  logic [15:0] mem_c0 [16], mem_c1 [16];
  logic        mem_h0 [16], mem_h1 [16];
  logic [15:0] mem_s0 [16], mem_s1 [16];
  logic [7:0]  mem_n0 [16], mem_n1 [16];

  int          lat = 1;
  int          pend_cnt = 0;
  logic [15:0] pend_addr;
  int          cyc = 0;
  int          n_fetch = 0;
  logic [15:0] fetch_log [32];
  int          fetch_cyc [32];
  int          n_leaf = 0;
  logic [15:0] ls_log [8];
  logic [7:0]  ln_log [8];
  int          zero_bad = 0;
  int          bp_left = 0, bp_cnt = 0, bp_bad = 0, bp_req = 0;
  logic [15:0] bp_s;
  logic [7:0]  bp_n;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      mem_hit[i] = 1'b0;
      mem_c0[i] = 16'h8000; mem_c1[i] = 16'h8000;
      mem_h0[i] = 1'b0;     mem_h1[i] = 1'b0;
      mem_s0[i] = 16'd0;    mem_s1[i] = 16'd0;
      mem_n0[i] = 8'd0;     mem_n1[i] = 8'd0;
    end
  endtask

  task automatic set_node(input int k, input logic h,
                          input logic [15:0] c0, input logic h0, input logic [15:0] s0, input logic [7:0] n0,
                          input logic [15:0] c1, input logic h1, input logic [15:0] s1, input logic [7:0] n1);
    mem_hit[k] = h;
    mem_c0[k] = c0; mem_h0[k] = h0; mem_s0[k] = s0; mem_n0[k] = n0;
    mem_c1[k] = c1; mem_h1[k] = h1; mem_s1[k] = s1; mem_n1[k] = n1;
  endtask

  task automatic clear_logs();
    n_fetch = 0; n_leaf = 0; bp_cnt = 0; bp_bad = 0; bp_req = 0;
  endtask

  // memory responder, leaf sink and output monitors, all acting on the falling edge
  initial begin
    node_valid = 1'b0; node_hit = 1'b0; leaf_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      child_idx[i] = '0; child_hit[i] = 1'b0; leaf_start[i] = '0; leaf_num[i] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      node_valid = 1'b0; node_hit = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          node_valid    = 1'b1;
          node_hit      = mem_hit[pend_addr[3:0]];
          child_idx[0]  = mem_c0[pend_addr[3:0]]; child_idx[1]  = mem_c1[pend_addr[3:0]];
          child_hit[0]  = mem_h0[pend_addr[3:0]]; child_hit[1]  = mem_h1[pend_addr[3:0]];
          leaf_start[0] = mem_s0[pend_addr[3:0]]; leaf_start[1] = mem_s1[pend_addr[3:0]];
          leaf_num[0]   = mem_n0[pend_addr[3:0]]; leaf_num[1]   = mem_n1[pend_addr[3:0]];
        end
      end
      if (node_req === 1'b1) begin
        if (n_fetch < 32) begin
          fetch_log[n_fetch] = node_addr;
          fetch_cyc[n_fetch] = cyc;
        end
        n_fetch++;
        pend_addr = node_addr;
        pend_cnt  = lat;
      end
      if (leaf_valid === 1'b0 && (out_start !== 16'd0 || out_num !== 8'd0)) zero_bad++;
      if (leaf_valid === 1'b1 && bp_left > 0) begin
        if (bp_cnt == 0) begin
          bp_s = out_start; bp_n = out_num;
        end else if (out_start !== bp_s || out_num !== bp_n) begin
          bp_bad++;
        end
        if (node_req !== 1'b0) bp_req++;
        leaf_ready = 1'b0;
        bp_left--;
        bp_cnt++;
      end else begin
        leaf_ready = 1'b1;
      end
      if (leaf_valid === 1'b1 && leaf_ready) begin
        if (n_leaf < 8) begin
          ls_log[n_leaf] = out_start;
          ln_log[n_leaf] = out_num;
        end
        n_leaf++;
      end
    end
  end

  task automatic run_trav(input string name, input int budget);
    int c;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    c = 0;
    while (done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({name, "_done"}, {31'd0, done}, 32'd1);
    chk({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic        hit;
    logic        h0, h1;
    logic [15:0] s0, s1;
    logic [7:0]  n0, n1;
    int          cnt;
    logic [15:0] es0, es1;
    logic [7:0]  en0, en1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'd5,     16'd6,     8'd1,   8'd1,   0, 16'd0,     16'd0,     8'd0,   8'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 16'd10,    16'd20,    8'd3,   8'd2,   2, 16'd10,    16'd20,    8'd3,   8'd2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'd7,     16'd9,     8'd4,   8'd5,   1, 16'd7,     16'd0,     8'd4,   8'd0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 16'd7,     16'd9,     8'd4,   8'd5,   1, 16'd9,     16'd0,     8'd5,   8'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 16'd1,     16'd2,     8'd0,   8'd6,   1, 16'd2,     16'd0,     8'd6,   8'd0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'd1,     16'd2,     8'd1,   8'd1,   0, 16'd0,     16'd0,     8'd0,   8'd0};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 16'h8000, 8'hFF, 8'h80, 2, 16'hFFFF, 16'h8000, 8'hFF, 8'h80};

    reset = 1'b1; start = 1'b0; abort = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    chk("reset_flags", {27'd0, node_req, leaf_valid, busy, done, overflow}, 32'd0);
    chk("reset_visited", {16'd0, nodes_visited}, 32'd0);
    chk("reset_addr", {16'd0, node_addr}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single-node trees: root with two leaf children
    for (int v = 0; v < 7; v++) begin
      clear_mem();
      set_node(0, vecs[v].hit, 16'h8000, vecs[v].h0, vecs[v].s0, vecs[v].n0,
                               16'h8001, vecs[v].h1, vecs[v].s1, vecs[v].n1);
      run_trav($sformatf("vec%0d", v), 200);
      chk($sformatf("vec%0d_visited", v), {16'd0, nodes_visited}, 32'd1);
      chk($sformatf("vec%0d_nfetch", v), n_fetch, 32'd1);
      chk($sformatf("vec%0d_addr0", v), {16'd0, fetch_log[0]}, 32'd0);
      chk($sformatf("vec%0d_nleaf", v), n_leaf, vecs[v].cnt);
      chk($sformatf("vec%0d_ovf", v), {31'd0, overflow}, 32'd0);
      if (vecs[v].cnt > 0) begin
        chk($sformatf("vec%0d_leaf0", v), {8'd0, ls_log[0], ln_log[0]}, {8'd0, vecs[v].es0, vecs[v].en0});
      end
      if (vecs[v].cnt > 1) begin
        chk($sformatf("vec%0d_leaf1", v), {8'd0, ls_log[1], ln_log[1]}, {8'd0, vecs[v].es1, vecs[v].en1});
      end
    end

    // two-level tree; child_hit of internal node 2 is 0 and must not matter
    clear_mem();
    set_node(0, 1'b1, 16'd1, 1'b1, 16'd0, 8'd0, 16'd2, 1'b0, 16'd0, 8'd0);
    set_node(1, 1'b1, 16'h8000, 1'b1, 16'd0, 8'd3, 16'h8001, 1'b1, 16'd3, 8'd2);
    run_trav("tree", 300);
    chk("tree_nfetch", n_fetch, 32'd3);
    chk("tree_order", {fetch_log[0][7:0], fetch_log[1][7:0], fetch_log[2][7:0]}, 32'h000102);
    chk("tree_nleaf", n_leaf, 32'd2);
    chk("tree_leaf0", {8'd0, ls_log[0], ln_log[0]}, {8'd0, 16'd0, 8'd3});
    chk("tree_leaf1", {8'd0, ls_log[1], ln_log[1]}, {8'd0, 16'd3, 8'd2});
    chk("tree_visited", {16'd0, nodes_visited}, 32'd3);
    chk("tree_latency", fetch_cyc[1] - fetch_cyc[0], 32'd5);

    // backpressure on the first leaf
    bp_left = 5;
    run_trav("bp", 300);
    chk("bp_hold", bp_cnt, 32'd5);
    chk("bp_stable", bp_bad, 32'd0);
    chk("bp_noreq", bp_req, 32'd0);
    chk("bp_nleaf", n_leaf, 32'd2);
    chk("bp_leaf0", {8'd0, ls_log[0], ln_log[0]}, {8'd0, 16'd0, 8'd3});
    chk("bp_leaf1", {8'd0, ls_log[1], ln_log[1]}, {8'd0, 16'd3, 8'd2});
    bp_left = 0;

    // overflow with a 2-entry stack: fetch order 0,1,4,2,5,6
    clear_mem();
    for (int k = 0; k < 4; k++)
      set_node(k, 1'b1, 16'(2*k+1), 1'b1, 16'd0, 8'd0, 16'(2*k+2), 1'b1, 16'd0, 8'd0);
    run_trav("ovf", 500);
    chk("ovf_flag", {31'd0, overflow}, 32'd1);
    chk("ovf_visited", {16'd0, nodes_visited}, 32'd6);
    chk("ovf_order", {fetch_log[0][3:0], fetch_log[1][3:0], fetch_log[2][3:0],
                      fetch_log[3][3:0], fetch_log[4][3:0], fetch_log[5][3:0], 8'd0},
                     32'h01425600);
    chk("ovf_nleaf", n_leaf, 32'd0);

    // new start clears the sticky overflow
    clear_mem();
    run_trav("clr", 200);
    chk("clr_ovf", {31'd0, overflow}, 32'd0);
    chk("clr_visited", {16'd0, nodes_visited}, 32'd1);

    // abort while waiting; late node_valid must be ignored
    clear_mem();
    set_node(0, 1'b1, 16'h8000, 1'b1, 16'd4, 8'd4, 16'h8001, 1'b1, 16'd5, 8'd5);
    lat = 3;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1; start = 1'b1;
    @(negedge clk); abort = 1'b0; start = 1'b0;
    chk("abort_state", {29'd0, busy, done, leaf_valid}, 32'd0);
    repeat (6) @(negedge clk);
    chk("abort_idle", {29'd0, busy, done, leaf_valid}, 32'd0);
    chk("abort_nleaf", n_leaf, 32'd0);
    chk("abort_nfetch", n_fetch, 32'd1);
    lat = 1;
    clear_mem();
    run_trav("restart", 200);
    chk("restart_addr", {16'd0, fetch_log[0]}, 32'd0);
    chk("restart_visited", {16'd0, nodes_visited}, 32'd1);

    // reset mid-traversal discards work and stops fetching
    clear_mem();
    set_node(0, 1'b1, 16'd1, 1'b1, 16'd0, 8'd0, 16'd2, 1'b1, 16'd0, 8'd0);
    set_node(1, 1'b1, 16'h8000, 1'b1, 16'd0, 8'd3, 16'h8001, 1'b1, 16'd3, 8'd2);
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk); reset = 1'b0;
    chk("rst_flags", {27'd0, node_req, leaf_valid, busy, done, overflow}, 32'd0);
    chk("rst_visited", {16'd0, nodes_visited}, 32'd0);
    repeat (10) @(negedge clk);
    chk("rst_nfetch", n_fetch, 32'd1);
    chk("rst_nleaf", n_leaf, 32'd0);
    chk("rst_idle", {30'd0, busy, done}, 32'd0);

    chk("zero_when_idle", zero_bad, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
